alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command initiator for the 4-bit accumulator ALU. Buffers a short program of (op, operand) pairs.
//  On start, issues the program to the ALU one command per cycle.
//  Optionally checks the ALU result against an internal shadow accumulator.
//  Sits between the host/test interface and the ALU's op/operand/result pins.
// PARAMETERS
//  DEPTH  8  program entries (power of 2, >=2)
//  OPW    4  operand/result width; must match the ALU width
// PORTS
//  clock        in   1      single clock, all state on posedge
//  reset_L      in   1      asynchronous, active-low reset
//  wr_valid     in   1      program write request
//  wr_ready     out  1      write accepted when wr_valid & wr_ready at posedge
//  wr_op        in   2      op code to store (op_t)
//  wr_operand   in   OPW    operand to store
//  clear        in   1      empty the program (IDLE only)
//  start        in   1      begin issuing the stored program
//  busy         out  1      high in RUN and DRAIN
//  done         out  1      one-cycle pulse after the last result is checked
//  alu_op       out  2      to ALU op
//  alu_operand  out  OPW    to ALU operand
//  alu_result   in   OPW    from ALU result (registered ALU state)
//  mismatch     out  1      sticky: result differed from the shadow model
//  err_count    out  4      saturating mismatch count (saturates at 15)
// BEHAVIOUR
//  Reset (async): state=IDLE, count=0, rd_ptr=0, shadow=0, mismatch=0, err_count=0, done=0, busy=0.
//   Program contents are don't-care after reset.
//  NOP: the ALU executes every cycle. Outside RUN drive alu_op=ADD, alu_operand=0 so the ALU holds.
//  States:
//   IDLE
//    - wr_ready = (count < DEPTH). An accepted write stores at index count; count increments.
//    - clear sets count=0; clear wins over a same-cycle write and over start.
//    - start with count>0 -> RUN, rd_ptr=0. start with count==0 is ignored.
//   RUN
//    - alu_op/alu_operand = mem[rd_ptr] (combinational); rd_ptr++ each cycle.
//    - When rd_ptr==count-1 -> DRAIN.
//    - wr_ready=0; write, clear and start are ignored.
//   DRAIN: drives NOP for one cycle so the final result is compared -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE. Program and count are retained; start reruns it.
//  Latency: entry k is presented in RUN cycle k and captured by the ALU at the end of that cycle.
//   The k-th result is compared in cycle k+1.
//   done rises N+1 cycles after the first RUN cycle, for N = count.
//  Arithmetic: shadow uses the same op semantics as the ALU, modulo 2^OPW.
//   Wrap-around on ADD/SUB is legal and is not an error.
//  The shadow updates on the same edge as the ALU (both RUN issues and NOPs), so it tracks the ALU across runs.
//  A compare is active in the cycle after every RUN issue: alu_result != shadow
//   -> mismatch<=1, err_count<=sat_inc(err_count).
//  mismatch/err_count clear only on reset.
//  Reset mid-run: everything returns to reset values immediately; the ALU resets on the same reset.
// CONFIGURATION
//  ALU_SEQ_CHECK_EN
//   - defined: shadow accumulator and compare logic present, as described above.
//   - undefined: no shadow/compare logic; mismatch and err_count are tied to 0; alu_result is unused.
//     Sequencing and timing are unchanged.
// STRUCTURE
//  alu_seq_pkg:
//   - op_t enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_OR=2'b10, OP_XOR=2'b11
//   - seq_state_t: IDLE, RUN, DRAIN, DONE
//   - NOP constants
//   - function alu_model(state, op, operand), shared with the bench scoreboard
//  Sub-module alu_seq_prog_mem: DEPTH x (2+OPW) register array; one write port, one async read port.
// TESTING
//  1 Reset -> busy=0, done=0, alu_op=00, alu_operand=0, wr_ready=1, mismatch=0, err_count=0.
//  2 Load ADD 5, SUB 3, XOR F, OR 1; start
//    -> ALU issues on 4 consecutive cycles; alu_result 5,2,D,D; done pulse 5 cycles after the first issue; mismatch=0.
//  3 Load ADD F, ADD 2, SUB 3 -> results F,1,E (wrap both ways); mismatch=0; rerun with no reload -> results D,F,C.
//  4 Write 9 entries with DEPTH=8 -> wr_ready drops after 8; 9th write not accepted; run issues exactly 8 commands.
//  5 Bench forces alu_result^=1 during RUN (CHECK_EN) -> mismatch=1 sticky; err_count increments per cycle, saturates at 15.
//  6 reset_L low mid-RUN -> IDLE, count=0, NOP driven; following start ignored; clear+wr_valid same cycle -> count stays 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types, NOP constants and the accumulator ALU reference function for the command sequencer.
package alu_seq_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  // ADD 0 leaves the ALU accumulator unchanged.
  localparam op_t              NOP_OP      = OP_ADD;
  localparam logic [ALU_W-1:0] NOP_OPERAND = '0;

  function automatic logic [ALU_W-1:0] alu_model(logic [ALU_W-1:0] state, op_t op,
                                                 logic [ALU_W-1:0] operand);
    logic [ALU_W-1:0] res;
    case (op)
      OP_ADD:  res = state + operand;
      OP_SUB:  res = state - operand;
      OP_OR:   res = state | operand;
      OP_XOR:  res = state ^ operand;
      default: res = state;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] sat_inc(logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'h1;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Host and ALU pin bundle for the command sequencer; master is the host/ALU side, slave the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned OPW = 4
);
  import alu_seq_pkg::*;

  logic           wr_valid;
  logic           wr_ready;
  op_t            wr_op;
  logic [OPW-1:0] wr_operand;
  logic           clear;
  logic           start;
  logic           busy;
  logic           done;
  op_t            alu_op;
  logic [OPW-1:0] alu_operand;
  logic [OPW-1:0] alu_result;
  logic           mismatch;
  logic [3:0]     err_count;

  modport master (
    output wr_valid, wr_op, wr_operand, clear, start, alu_result,
    input  wr_ready, busy, done, alu_op, alu_operand, mismatch, err_count
  );

  modport slave (
    input  wr_valid, wr_op, wr_operand, clear, start, alu_result,
    output wr_ready, busy, done, alu_op, alu_operand, mismatch, err_count
  );

endinterface

// File: rtl/alu_seq_prog_mem.sv
// Program store: DEPTH entries of (op, operand), one synchronous write port, one async read port.
module alu_seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OPW   = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            we,
  input  logic [PtrW-1:0] waddr,
  input  op_t             wop,
  input  logic [OPW-1:0]  woperand,
  input  logic [PtrW-1:0] raddr,
  output op_t             rop,
  output logic [OPW-1:0]  roperand
);

  op_t            mem_op   [DEPTH];
  logic [OPW-1:0] mem_opnd [DEPTH];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_op[waddr]   <= wop;
      mem_opnd[waddr] <= woperand;
    end
  end

  assign rop      = mem_op[raddr];
  assign roperand = mem_opnd[raddr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers a short (op, operand) program and issues it to the accumulator ALU one command per cycle.
// Define ALU_SEQ_CHECK_EN to build the shadow accumulator and result compare.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OPW   = 4
) (
  input logic                 clock,
  input logic                 reset_L,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  seq_state_t      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic           wr_ready;
  logic           busy;
  logic           done;
  logic           mem_we;
  op_t            alu_op;
  logic [OPW-1:0] alu_operand;
  op_t            mem_op;
  logic [OPW-1:0] mem_operand;

  alu_seq_prog_mem #(
    .DEPTH (DEPTH),
    .OPW   (OPW)
  ) u_prog_mem (
    .clock    (clock),
    .we       (mem_we),
    .waddr    (count_q[PtrW-1:0]),
    .wop      (bus.wr_op),
    .woperand (bus.wr_operand),
    .raddr    (rd_ptr_q),
    .rop      (mem_op),
    .roperand (mem_operand)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    alu_op      = NOP_OP;
    alu_operand = '0;

    unique case (state_q)
      IDLE: begin
        wr_ready = (count_q < CntW'(DEPTH));
        if (bus.clear) begin
          // Clear beats a same-cycle write and start.
          count_d = '0;
        end else begin
          if (bus.wr_valid && wr_ready) begin
            mem_we  = 1'b1;
            count_d = count_q + CntW'(1);
          end
          if (bus.start && (count_q != '0)) begin
            state_d  = RUN;
            rd_ptr_d = '0;
          end
        end
      end
      RUN: begin
        busy        = 1'b1;
        alu_op      = mem_op;
        alu_operand = mem_operand;
        rd_ptr_d    = rd_ptr_q + PtrW'(1);
        if (CntW'(rd_ptr_q) == count_q - CntW'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.alu_op      = alu_op;
  assign bus.alu_operand = alu_operand;

`ifdef ALU_SEQ_CHECK_EN
  logic [OPW-1:0] shadow_q;
  logic           chk_q;
  logic           mismatch_q;
  logic [3:0]     err_q;

  // Shadow advances on every edge, NOPs included, so it tracks the ALU across runs.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      shadow_q   <= '0;
      chk_q      <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      shadow_q <= alu_model(shadow_q, alu_op, alu_operand);
      chk_q    <= (state_q == RUN);
      if (chk_q && (bus.alu_result != shadow_q)) begin
        mismatch_q <= 1'b1;
        err_q      <= sat_inc(err_q);
      end
    end
  end

  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_q;
`else
  logic unused_result;
  assign unused_result = ^bus.alu_result;
  assign bus.mismatch  = 1'b0;
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural accumulator ALU on the command pins.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic clock;
  logic reset_L;
  logic [3:0] acc;
  logic fault_en;
  int checks;
  int errors;

  alu_cmd_sequencer_if #(.OPW(4)) bus ();

  alu_cmd_sequencer #(
    .DEPTH (8),
    .OPW   (4)
  ) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU: registered accumulator, reset with the sequencer.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) acc <= '0;
    else          acc <= alu_model(acc, bus.alu_op, bus.alu_operand);
  end
  assign bus.alu_result = acc ^ {3'b000, fault_en & bus.busy};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic write_entry(input op_t op, input logic [3:0] v, input logic exp_ready,
                             input string tag);
    bus.wr_valid   = 1'b1;
    bus.wr_op      = op;
    bus.wr_operand = v;
    check(tag, bus.wr_ready, exp_ready);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic run_prog(input int n, input logic [3:0] exp [8], input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check($sformatf("%s busy0", tag), bus.busy, 1);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s res%0d", tag, k), bus.alu_result, exp[k]);
    end
    check($sformatf("%s drain_busy", tag), bus.busy, 1);
    check($sformatf("%s drain_done", tag), bus.done, 0);
    check($sformatf("%s drain_nop", tag), bus.alu_operand, 0);
    tick();
    check($sformatf("%s done", tag), bus.done, 1);
    tick();
    check($sformatf("%s done_low", tag), bus.done, 0);
    check($sformatf("%s idle_busy", tag), bus.busy, 0);
  endtask

  task automatic start_wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check(tag, seen, 1);
    tick();
  endtask

  initial begin
    logic [3:0] e [8];
    checks         = 0;
    errors         = 0;
    fault_en       = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_op      = OP_ADD;
    bus.wr_operand = '0;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;

    // 1: reset state
    do_reset();
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst alu_op", bus.alu_op, 0);
    check("rst alu_operand", bus.alu_operand, 0);
    check("rst wr_ready", bus.wr_ready, 1);
    check("rst mismatch", bus.mismatch, 0);
    check("rst err_count", bus.err_count, 0);

    // 2: four-command program
    write_entry(OP_ADD, 4'h5, 1'b1, "t2 w0");
    write_entry(OP_SUB, 4'h3, 1'b1, "t2 w1");
    write_entry(OP_XOR, 4'hF, 1'b1, "t2 w2");
    write_entry(OP_OR,  4'h1, 1'b1, "t2 w3");
    e = '{4'h5, 4'h2, 4'hD, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
    run_prog(4, e, "t2");
    check("t2 mismatch", bus.mismatch, 0);

    // 3: wrap-around both ways, then rerun without reloading
    do_reset();
    write_entry(OP_ADD, 4'hF, 1'b1, "t3 w0");
    write_entry(OP_ADD, 4'h2, 1'b1, "t3 w1");
    write_entry(OP_SUB, 4'h3, 1'b1, "t3 w2");
    e = '{4'hF, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_prog(3, e, "t3a");
    check("t3a mismatch", bus.mismatch, 0);
    e = '{4'hD, 4'hF, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_prog(3, e, "t3b");
    check("t3b mismatch", bus.mismatch, 0);

    // 4: overfill; the ninth write must be refused
    do_clear();
    for (int i = 0; i < 8; i++) write_entry(OP_ADD, 4'h1, 1'b1, $sformatf("t4 w%0d", i));
    write_entry(OP_ADD, 4'h7, 1'b0, "t4 w8");
    e = '{4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    run_prog(8, e, "t4");
    check("t4 mismatch", bus.mismatch, 0);

    // 5: corrupt the ALU result while busy
    fault_en = 1'b1;
    start_wait_done("t5 run1 done");
`ifdef ALU_SEQ_CHECK_EN
    check("t5 run1 mismatch", bus.mismatch, 1);
    check("t5 run1 err_count", bus.err_count, 8);
    start_wait_done("t5 run2 done");
    check("t5 run2 err_count", bus.err_count, 15);
    fault_en = 1'b0;
    start_wait_done("t5 run3 done");
    check("t5 run3 mismatch", bus.mismatch, 1);
    check("t5 run3 err_count", bus.err_count, 15);
`else
    check("t5 mismatch tied", bus.mismatch, 0);
    check("t5 err_count tied", bus.err_count, 0);
`endif
    fault_en = 1'b0;

    // 6: reset in the middle of a run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("t6 pre busy", bus.busy, 1);
    reset_L = 1'b0;
    #1;
    check("t6 rst busy", bus.busy, 0);
    check("t6 rst alu_op", bus.alu_op, 0);
    check("t6 rst alu_operand", bus.alu_operand, 0);
    check("t6 rst mismatch", bus.mismatch, 0);
    check("t6 rst err_count", bus.err_count, 0);
    check("t6 rst alu_result", bus.alu_result, 0);
    tick();
    reset_L = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6 start ignored", bus.busy, 0);
    bus.clear      = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_op      = OP_ADD;
    bus.wr_operand = 4'h9;
    tick();
    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6 clear beats write", bus.busy, 0);
    tick();
    check("t6 still idle", bus.busy, 0);
    check("t6 acc held", bus.alu_result, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
